// File: rtl/iomem_mailbox_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iomem_mailbox_pkg                                                     |
// | Register offsets, STATUS/IRQ_EN/CTRL bit positions and FSM encoding   |
// | shared by the iomem mailbox responder.                                |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package iomem_mailbox_pkg;

    localparam logic [5:0] c_off_data   = 6'h00;
    localparam logic [5:0] c_off_status = 6'h01;
    localparam logic [5:0] c_off_irq_en = 6'h02;
    localparam logic [5:0] c_off_ctrl   = 6'h03;

    localparam int c_stat_rx_empty = 0;
    localparam int c_stat_rx_full  = 1;
    localparam int c_stat_tx_empty = 2;
    localparam int c_stat_tx_full  = 3;
    localparam int c_stat_rx_count = 8;
    localparam int c_stat_tx_count = 16;
    localparam int c_stat_count_w  = 5;

    localparam int c_irq_rx_ne = 0;
    localparam int c_irq_tx_e  = 1;

    localparam int c_ctrl_flush_rx = 0;
    localparam int c_ctrl_flush_tx = 1;

    localparam logic [31:0] c_empty_read = 32'hFFFF_FFFF;

    localparam logic [1:0] c_state_idle = 2'd0;
    localparam logic [1:0] c_state_wait = 2'd1;
    localparam logic [1:0] c_state_resp = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mailbox_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mailbox_fifo                                                          |
// | Synchronous show-ahead FIFO with flush; DEPTH must be a power of two. |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module mailbox_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_depth);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/iomem_mailbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iomem_mailbox                                                         |
// | PicoSoC iomem responder with RX/TX word FIFOs and a level interrupt.  |
// | Optional feature macro: IOMEM_MAILBOX_IRQ_EN (IRQ_EN register + irq). |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module iomem_mailbox
    import iomem_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          DEPTH     = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_rdata;
    logic [31:0] w_rd_data;
    logic [31:0] w_status;
    logic [5:0]  w_offset;
    logic        w_sel, w_is_write, w_stall, w_req, w_accept, w_ctrl_wr;
    logic        w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic [31:0] w_rx_rdata;
    logic [CW-1:0] w_rx_count, w_tx_count;
    logic [c_stat_count_w-1:0] w_rx_cnt_ext, w_tx_cnt_ext;
    logic [1:0]  w_irq_en;
    logic        w_unused_ok;

    assign w_sel      = (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign w_offset   = iomem_addr[7:2];
    assign w_is_write = |iomem_wstrb;
    assign w_stall    = w_is_write && (w_offset == c_off_data) && w_tx_full;
    assign w_req      = iomem_valid && w_sel && (r_state != c_state_resp);
    assign w_accept   = w_req && !w_stall;
    assign w_ctrl_wr  = w_accept && w_is_write && (w_offset == c_off_ctrl) && iomem_wstrb[0];

    assign iomem_ready = (r_state == c_state_resp);
    assign iomem_rdata = r_rdata;
    assign in_ready    = !w_rx_full;
    assign out_valid   = !w_tx_empty;
    assign w_unused_ok = &{1'b0, iomem_addr[1:0], iomem_wdata[31:2]};

    mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (in_valid && !w_rx_full),
        .pop    (w_accept && !w_is_write && (w_offset == c_off_data) && !w_rx_empty),
        .flush  (w_ctrl_wr && iomem_wdata[c_ctrl_flush_rx]),
        .wdata  (in_data),
        .rdata  (w_rx_rdata),
        .full   (w_rx_full),
        .empty  (w_rx_empty),
        .count  (w_rx_count)
    );

    mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_accept && w_is_write && (w_offset == c_off_data)),
        .pop    (out_ready && !w_tx_empty),
        .flush  (w_ctrl_wr && iomem_wdata[c_ctrl_flush_tx]),
        .wdata  (iomem_wdata),
        .rdata  (out_data),
        .full   (w_tx_full),
        .empty  (w_tx_empty),
        .count  (w_tx_count)
    );

    always_comb begin
        w_rx_cnt_ext         = '0;
        w_tx_cnt_ext         = '0;
        w_rx_cnt_ext[CW-1:0] = w_rx_count;
        w_tx_cnt_ext[CW-1:0] = w_tx_count;
        w_status                  = '0;
        w_status[c_stat_rx_empty] = w_rx_empty;
        w_status[c_stat_rx_full]  = w_rx_full;
        w_status[c_stat_tx_empty] = w_tx_empty;
        w_status[c_stat_tx_full]  = w_tx_full;
        w_status[c_stat_rx_count +: c_stat_count_w] = w_rx_cnt_ext;
        w_status[c_stat_tx_count +: c_stat_count_w] = w_tx_cnt_ext;
    end

    // Writes and CTRL/unmapped reads return 0 so the bus can OR responders.
    always_comb begin
        w_rd_data = '0;
        if (!w_is_write) begin
            case (w_offset)
                c_off_data:   w_rd_data = w_rx_empty ? c_empty_read : w_rx_rdata;
                c_off_status: w_rd_data = w_status;
                c_off_irq_en: w_rd_data = {30'd0, w_irq_en};
                default:      w_rd_data = '0;
            endcase
        end
    end

    always_comb begin
        w_state_next = c_state_idle;
        case (r_state)
            c_state_idle, c_state_wait: begin
                if (w_accept)   w_state_next = c_state_resp;
                else if (w_req) w_state_next = c_state_wait;
            end
            default: w_state_next = c_state_idle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_state_idle;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_rdata <= w_accept ? w_rd_data : 32'd0;
        end
    end

`ifdef IOMEM_MAILBOX_IRQ_EN
    logic [1:0] r_irq_en;
    logic       r_irq;
    logic       w_irq_en_wr;

    assign w_irq_en_wr = w_accept && w_is_write && (w_offset == c_off_irq_en) && iomem_wstrb[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_irq_en_wr) r_irq_en <= iomem_wdata[1:0];
            r_irq <= (r_irq_en[c_irq_rx_ne] & ~w_rx_empty) | (r_irq_en[c_irq_tx_e] & w_tx_empty);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 2'b00;
    assign irq      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iomem_mailbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_iomem_mailbox                                                      |
// | Scoreboard bench: queue-based mailbox model, directed + random ops.   |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_iomem_mailbox;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'd0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic [31:0] iomem_rdata;
    logic        irq;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    iomem_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .irq(irq),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    logic [31:0] rx_q[$];
    logic [31:0] tx_q[$];
    logic [1:0]  irq_en_m = 2'b00;
    exp_t        mon_e;
    logic        prev_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] status_model();
        logic [31:0] s;
        s        = 32'd0;
        s[0]     = (rx_q.size() == 0);
        s[1]     = (rx_q.size() == DEPTH);
        s[2]     = (tx_q.size() == 0);
        s[3]     = (tx_q.size() == DEPTH);
        s[12:8]  = 5'(rx_q.size());
        s[20:16] = 5'(tx_q.size());
        return s;
    endfunction

    function automatic logic irq_model();
`ifdef IOMEM_MAILBOX_IRQ_EN
        return (irq_en_m[0] && rx_q.size() != 0) || (irq_en_m[1] && tx_q.size() == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Bus monitor: pops one expectation per ready pulse; fabric-out monitor checks TX order.
    always @(negedge clk) begin
        if (iomem_ready) begin
            if (prev_ready) flag("ready_longer_than_one_cycle");
            else if (exp_q.size() == 0) flag("unexpected_ready");
            else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) check(mon_e.name, iomem_rdata, mon_e.val);
            end
        end else if (prev_ready) begin
            check("rdata_zero_after_ready", iomem_rdata, 32'd0);
        end
        prev_ready = iomem_ready;
        if (out_valid && out_ready) begin
            if (tx_q.size() == 0) flag("unexpected_out_transfer");
            else check("out_data", out_data, tx_q.pop_front());
        end
    end

    task automatic cpu(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                       input bit chk, input logic [31:0] expv, input string name, output int lat);
        exp_t e;
        e.chk = chk; e.val = expv; e.name = name;
        exp_q.push_back(e);
        @(posedge clk); #1;
        iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = wstrb; iomem_wdata = wdata;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!iomem_ready && lat < 200);
        iomem_valid = 1'b0; iomem_wstrb = 4'd0;
        if (!iomem_ready) begin
            flag({name, "_timeout"});
            exp_q.delete(exp_q.size() - 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic rd_data();
        int l;
        logic [31:0] v;
        v = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hFFFF_FFFF;
        cpu(BASE, 4'd0, 32'd0, 1'b1, v, "data_read", l);
    endtask

    task automatic wr_data(input logic [31:0] d);
        int l;
        tx_q.push_back(d);
        cpu(BASE, 4'($urandom_range(1, 15)), d, 1'b0, 32'd0, "data_write", l);
    endtask

    task automatic rd_status(input string name);
        int l;
        cpu(BASE + 32'h4, 4'd0, 32'd0, 1'b1, status_model(), name, l);
    endtask

    task automatic wr_irq_en(input logic [3:0] wstrb, input logic [31:0] d);
        int l;
`ifdef IOMEM_MAILBOX_IRQ_EN
        if (wstrb[0]) irq_en_m = d[1:0];
`endif
        cpu(BASE + 32'h8, wstrb, d, 1'b0, 32'd0, "irq_en_write", l);
    endtask

    task automatic rd_irq_en();
        int l;
        cpu(BASE + 32'h8, 4'd0, 32'd0, 1'b1, {30'd0, irq_en_m}, "irq_en_read", l);
    endtask

    task automatic wr_ctrl(input logic [3:0] wstrb, input logic [31:0] d);
        int l;
        if (wstrb[0] && d[0]) rx_q.delete();
        if (wstrb[0] && d[1]) tx_q.delete();
        cpu(BASE + 32'hC, wstrb, d, 1'b0, 32'd0, "ctrl_write", l);
    endtask

    task automatic fab_push(input logic [31:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d;
        check("in_ready", in_ready, (rx_q.size() < DEPTH));
        if (rx_q.size() < DEPTH) rx_q.push_back(d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic fab_pop();
        @(posedge clk); #1;
        check("out_valid", out_valid, (tx_q.size() != 0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_irq(input string name);
        @(posedge clk); #1;
        check(name, irq, irq_model());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        int unsigned op;
        logic [31:0] d;
        logic [3:0]  ws;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", iomem_ready, 1'b0);
        check("reset_rdata", iomem_rdata, 32'd0);
        check("reset_irq", irq, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        resetn = 1'b1;

        cpu(BASE + 32'h4, 4'd0, 32'd0, 1'b1, 32'h0000_0005, "status_after_reset", lat);
        check("read_latency", lat, 1);
        check("irq_idle", irq, 1'b0);

        // RX ordering and empty read
        fab_push(32'hA5A5_0001);
        fab_push(32'hA5A5_0002);
        rd_status("rx_count_2");
        rd_data();
        rd_status("rx_count_1");
        rd_data();
        rd_status("rx_count_0");
        rd_data();

        // TX full, stalled write released by one fabric pop
        for (int i = 0; i < DEPTH; i++) wr_data(32'hC0DE_0000 + i);
        rd_status("tx_full_status");
        fork
            wr_data(32'hC0DE_0017);
            begin
                repeat (5) @(posedge clk);
                #1;
                check("stalled_write_no_ready", iomem_ready, 1'b0);
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                k = 0;
                while (!iomem_ready && k < 10) begin
                    @(posedge clk); #1;
                    k++;
                end
                check("stall_release_latency", (k >= 1 && k <= 2), 1'b1);
            end
        join
        rd_status("tx_still_full");
        for (int i = 0; i < DEPTH; i++) fab_pop();
        rd_status("tx_drained");

        // Interrupt behaviour
        wr_irq_en(4'b0001, 32'h1);
        check_irq("irq_rx_enabled_empty");
        fab_push(32'h1234_5678);
        check("irq_one_cycle_after_push", irq, 1'b0);
        check_irq("irq_two_cycles_after_push");
        rd_data();
        check_irq("irq_after_pop");
        rd_irq_en();
        wr_irq_en(4'b0001, 32'h2);
        check_irq("irq_tx_empty");
        wr_data(32'h5555_AAAA);
        check_irq("irq_tx_not_empty");
        fab_pop();
        check_irq("irq_tx_empty_again");
        wr_irq_en(4'b0010, 32'h3);
        rd_irq_en();
        wr_irq_en(4'b0001, 32'h0);
        check_irq("irq_disabled");

        // RX full: CPU pop and refused fabric push in the same cycle
        for (int i = 0; i < DEPTH; i++) fab_push(32'hB000_0000 + i);
        rd_status("rx_full_status");
        fork
            rd_data();
            begin
                @(posedge clk); #1;
                in_valid = 1'b1; in_data = 32'hBAD0_BAD0;
                check("in_ready_while_full", in_ready, 1'b0);
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        join
        rd_status("rx_count_15");
        fab_push(32'hB000_00FF);
        rd_status("rx_count_16");

        // Flushes and quiet registers
        wr_ctrl(4'b0001, 32'h1);
        rd_status("rx_flushed");
        wr_data(32'h7777_0001);
        wr_data(32'h7777_0002);
        wr_ctrl(4'b0001, 32'h2);
        rd_status("tx_flushed");
        cpu(BASE + 32'hC, 4'd0, 32'd0, 1'b1, 32'd0, "ctrl_reads_zero", lat);
        cpu(BASE + 32'h40, 4'd0, 32'd0, 1'b1, 32'd0, "unmapped_reads_zero", lat);

        // Randomised traffic against the queue model
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            d  = $urandom;
            ws = 4'($urandom_range(1, 15));
            case (op)
                0, 1: fab_push(d);
                2, 3: rd_data();
                4: if (tx_q.size() < DEPTH) wr_data(d); else fab_pop();
                5: fab_pop();
                6: rd_status("rand_status");
                7: begin wr_irq_en(ws, d); rd_irq_en(); end
                8: if ($urandom_range(0, 3) == 0) wr_ctrl(ws, d);
                   else cpu(BASE + (32'($urandom_range(4, 63)) << 2), 4'd0, 32'd0, 1'b1, 32'd0,
                            "rand_unmapped", lat);
                default: cpu(BASE + (32'($urandom_range(4, 63)) << 2), ws, d, 1'b0, 32'd0,
                             "rand_unmapped_write", lat);
            endcase
            check_irq("rand_irq");
        end
        rd_status("rand_final_status");

        // Outside the window: no response at all
        @(posedge clk); #1;
        iomem_valid = 1'b1; iomem_addr = BASE + 32'h100; iomem_wstrb = 4'd0;
        repeat (4) begin
            @(posedge clk); #1;
            check("out_of_window_ready", iomem_ready, 1'b0);
            check("out_of_window_rdata", iomem_rdata, 32'd0);
        end
        iomem_valid = 1'b0;

        // Reset during a stalled write
        while (tx_q.size() < DEPTH) wr_data($urandom);
        @(posedge clk); #1;
        iomem_valid = 1'b1; iomem_addr = BASE; iomem_wstrb = 4'hF; iomem_wdata = 32'hDEAD_BEEF;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_before_reset", iomem_ready, 1'b0);
        end
        resetn = 1'b0;
        #2;
        iomem_valid = 1'b0; iomem_wstrb = 4'd0;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_ready_in_reset", iomem_ready, 1'b0);
        end
        resetn = 1'b1;
        rx_q.delete();
        tx_q.delete();
        irq_en_m = 2'b00;
        check("out_valid_after_reset", out_valid, 1'b0);
        check("in_ready_after_reset", in_ready, 1'b1);
        cpu(BASE + 32'h4, 4'd0, 32'd0, 1'b1, 32'h0000_0005, "status_after_midreset", lat);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
